// File: rtl/ddr2_app_pkg.sv
// Shared definitions for the DDR2 application-side responder.
// Command codes, queue widths, FSM states and error bit positions.
package ddr2_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int AF_W  = 34;
  localparam int WDF_W = 144;

  localparam int ERR_AF  = 0;
  localparam int ERR_WDF = 1;
  localparam int ERR_CMD = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_WR1,
    ST_RD_WAIT,
    ST_RD0,
    ST_RD1
  } state_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO used for the command and write-data queues.
// Full push is dropped unless a pop frees the slot in the same cycle.
module resp_fifo #(
  parameter int W        = 8,
  parameter int DEPTH    = 4,
  parameter int AFULL_AT = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic                     afull,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          push_ok;
  logic          pop_ok;
  logic [CW-1:0] count_nxt;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  assign dout      = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      afull <= 1'b0;
    end else begin
      if (push_ok)
        wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (pop_ok)
        rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      count <= count_nxt;
      afull <= (count_nxt >= CW'(AFULL_AT));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wp] <= din;
  end

endmodule

// File: rtl/ddr2_app_responder.sv
// Stand-in for the DDR2 controller app interface, backed by a
// byte-enabled block-RAM store with fixed read latency.
module ddr2_app_responder
  import ddr2_app_pkg::*;
#(
  parameter int MEM_AW    = 10,
  parameter int RD_LAT    = 4,
  parameter int AF_DEPTH  = 4,
  parameter int WDF_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          app_af_wren,
  input  logic [2:0]    app_af_cmd,
  input  logic [30:0]   app_af_addr,
  output logic          app_af_afull,
  input  logic          app_wdf_wren,
  input  logic [127:0]  app_wdf_data,
  input  logic [15:0]   app_wdf_mask_data,
  output logic          app_wdf_afull,
  output logic          rd_data_valid,
  output logic [127:0]  rd_data_fifo_out,
  output logic [2:0]    err_flags
);

  localparam int BW = MEM_AW - 1;
  localparam logic [3:0] LAT_M2 =
    (RD_LAT >= 2) ? 4'(RD_LAT - 2) : 4'd0;

  state_t state;
  logic [3:0] cnt;
  logic [BW-1:0] rw_base;

  logic [AF_W-1:0] af_dout;
  logic af_full;
  logic af_empty;
  logic af_pop;
  logic [$clog2(AF_DEPTH):0] af_count;

  logic [WDF_W-1:0] wdf_dout;
  logic wdf_full;
  logic wdf_empty;
  logic wdf_pop;
  logic [$clog2(WDF_DEPTH):0] wdf_count;

  logic [2:0] af_cmd;
  logic [30:0] af_addr;
  logic is_wr;
  logic is_rd;
  logic af_drop;
  logic wdf_drop;
  logic beat_ld;
  logic [MEM_AW-1:0] waddr;
  logic [MEM_AW-1:0] raddr;
  logic [127:0] wdata;
  logic [15:0] wmask;

  logic [127:0] mem [2**MEM_AW];

  resp_fifo #(
    .W(AF_W), .DEPTH(AF_DEPTH), .AFULL_AT(AF_DEPTH - 1)
  ) u_af (
    .clk(clk), .rst_n(rst_n),
    .push(app_af_wren),
    .din({app_af_cmd, app_af_addr}),
    .pop(af_pop),
    .dout(af_dout),
    .full(af_full), .empty(af_empty),
    .afull(app_af_afull), .count(af_count)
  );

  resp_fifo #(
    .W(WDF_W), .DEPTH(WDF_DEPTH), .AFULL_AT(WDF_DEPTH - 2)
  ) u_wdf (
    .clk(clk), .rst_n(rst_n),
    .push(app_wdf_wren),
    .din({app_wdf_mask_data, app_wdf_data}),
    .pop(wdf_pop),
    .dout(wdf_dout),
    .full(wdf_full), .empty(wdf_empty),
    .afull(app_wdf_afull), .count(wdf_count)
  );

  assign af_cmd  = af_dout[33:31];
  assign af_addr = af_dout[30:0];
  assign wmask   = wdf_dout[143:128];
  assign wdata   = wdf_dout[127:0];
  assign is_wr   = (af_cmd == CMD_WRITE);
  assign is_rd   = (af_cmd == CMD_READ);

  assign af_pop  = (state == ST_IDLE) && !af_empty;
  assign wdf_pop = ((state == ST_WR0) || (state == ST_WR1))
                   && !wdf_empty;

  assign af_drop  = app_af_wren && af_full && !af_pop;
  assign wdf_drop = app_wdf_wren && wdf_full && !wdf_pop;

  assign waddr = {rw_base, (state == ST_WR1)};

  // Store address runs one cycle ahead of the beat it feeds.
  assign raddr = (state == ST_IDLE) ?
                 {af_addr[MEM_AW:2], 1'b0} :
                 {rw_base, (state == ST_RD0)};

  assign beat_ld = ((state == ST_RD_WAIT) && (cnt == 4'd0))
                || (state == ST_RD0)
                || ((RD_LAT == 1) && af_pop && is_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      rw_base       <= '0;
      err_flags     <= 3'b000;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= beat_ld;
      if (af_drop)
        err_flags[ERR_AF] <= 1'b1;
      if (wdf_drop)
        err_flags[ERR_WDF] <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (!af_empty) begin
            rw_base <= af_addr[MEM_AW:2];
            unique case (1'b1)
              is_wr: state <= ST_WR0;
              is_rd: begin
                state <= (RD_LAT == 1) ? ST_RD0 : ST_RD_WAIT;
                cnt   <= LAT_M2;
              end
              default: err_flags[ERR_CMD] <= 1'b1;
            endcase
          end
        end
        ST_WR0: begin
          if (!wdf_empty)
            state <= ST_WR1;
        end
        ST_WR1: begin
          if (!wdf_empty)
            state <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (cnt == 4'd0)
            state <= ST_RD0;
          else
            cnt <= cnt - 4'd1;
        end
        ST_RD0: state <= ST_RD1;
        ST_RD1: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data_fifo_out <= '0;
    else if (beat_ld)
      rd_data_fifo_out <= mem[raddr];
  end

  // Mask bit set means the byte keeps its old value.
  always_ff @(posedge clk) begin
    if (wdf_pop) begin
      for (int b = 0; b < 16; b++) begin
        if (!wmask[b])
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{af_count, wdf_count};

endmodule

// File: tb/tb_ddr2_app_responder.sv
// Scoreboard bench for ddr2_app_responder: directed writes/reads,
// masking, late data, overflow, illegal command, wrap and reset abort.
module tb_ddr2_app_responder;
  import ddr2_app_pkg::*;

  localparam int MEM_AW = 10;
  localparam int RD_LAT = 4;

  logic         clk;
  logic         rst_n;
  logic         app_af_wren;
  logic [2:0]   app_af_cmd;
  logic [30:0]  app_af_addr;
  logic         app_af_afull;
  logic         app_wdf_wren;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask_data;
  logic         app_wdf_afull;
  logic         rd_data_valid;
  logic [127:0] rd_data_fifo_out;
  logic [2:0]   err_flags;

  ddr2_app_responder #(
    .MEM_AW(MEM_AW), .RD_LAT(RD_LAT),
    .AF_DEPTH(4), .WDF_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .app_af_wren(app_af_wren),
    .app_af_cmd(app_af_cmd),
    .app_af_addr(app_af_addr),
    .app_af_afull(app_af_afull),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_data(app_wdf_data),
    .app_wdf_mask_data(app_wdf_mask_data),
    .app_wdf_afull(app_wdf_afull),
    .rd_data_valid(rd_data_valid),
    .rd_data_fifo_out(rd_data_fifo_out),
    .err_flags(err_flags)
  );

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  localparam logic [127:0] D1A = {32{4'h1}};
  localparam logic [127:0] D1B = {32{4'h2}};
  localparam logic [127:0] ALL1 = {16{8'hFF}};
  localparam logic [127:0] MSKD = {{15{8'hFF}}, 8'h00};
  localparam logic [127:0] D3A = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] D3B = {4{32'hCAFE_F00D}};
  localparam logic [127:0] D4A = {8{16'h4A4A}};
  localparam logic [127:0] D4B = {8{16'h4B4B}};
  localparam logic [127:0] D5A = {16{8'h5A}};
  localparam logic [127:0] D5B = {16{8'hA5}};

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [127:0] act,
                       logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_data_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h at cycle %0d expected none",
                 rd_data_fifo_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("beat_data", rd_data_fifo_out, mon_e.data);
        if (mon_e.cyc >= 0)
          check("beat_cycle", 128'(cyc), 128'(mon_e.cyc));
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(logic [2:0] c, logic [30:0] a);
    app_af_wren = 1'b1;
    app_af_cmd  = c;
    app_af_addr = a;
    tick();
    app_af_wren = 1'b0;
  endtask

  task automatic push_data(logic [127:0] d, logic [15:0] m);
    app_wdf_wren      = 1'b1;
    app_wdf_data      = d;
    app_wdf_mask_data = m;
    tick();
    app_wdf_wren = 1'b0;
  endtask

  task automatic do_write(logic [30:0] a,
                          logic [127:0] d0, logic [15:0] m0,
                          logic [127:0] d1, logic [15:0] m1);
    push_cmd(CMD_WRITE, a);
    push_data(d0, m0);
    push_data(d1, m1);
  endtask

  task automatic exp_beat(logic [127:0] d, int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Timed reads assume the FSM is idle when the command is pushed.
  task automatic do_read(logic [30:0] a, logic [127:0] d0,
                         logic [127:0] d1, bit timed);
    int p;
    p = cyc;
    exp_beat(d0, timed ? p + 1 + RD_LAT : -1);
    exp_beat(d1, timed ? p + 2 + RD_LAT : -1);
    push_cmd(CMD_READ, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() > 0; i++)
      tick();
    check("drain_timeout", 128'(sb.size()), 128'd0);
    sb.delete();
  endtask

  initial begin
    rst_n             = 1'b0;
    app_af_wren       = 1'b0;
    app_af_cmd        = 3'b000;
    app_af_addr       = '0;
    app_wdf_wren      = 1'b0;
    app_wdf_data      = '0;
    app_wdf_mask_data = '0;
    tick(3);
    check("rst_valid", 128'(rd_data_valid), 128'd0);
    check("rst_data", rd_data_fifo_out, 128'd0);
    check("rst_af_afull", 128'(app_af_afull), 128'd0);
    check("rst_wdf_afull", 128'(app_wdf_afull), 128'd0);
    check("rst_err", 128'(err_flags), 128'd0);
    rst_n = 1'b1;
    tick(2);

    // write then read with latency check
    do_write(31'h8, D1A, 16'h0, D1B, 16'h0);
    tick(4);
    do_read(31'h8, D1A, D1B, 1'b1);
    drain();

    // byte mask: only byte 0 rewritten
    do_write(31'h10, ALL1, 16'h0, ALL1, 16'h0);
    do_write(31'h10, '0, 16'hFFFE, '0, 16'hFFFE);
    tick(4);
    do_read(31'h10, MSKD, MSKD, 1'b1);
    drain();

    // data arrives late; read queued behind must see it
    push_cmd(CMD_WRITE, 31'h20);
    do_read(31'h20, D3A, D3B, 1'b0);
    tick(10);
    check("late_read_held", 128'(sb.size()), 128'd2);
    push_data(D3A, 16'h0);
    push_data(D3B, 16'h0);
    drain();

    // command overflow behind a blocked write
    push_cmd(CMD_WRITE, 31'h30);
    tick(2);
    exp_beat(D1A, -1);
    exp_beat(D1B, -1);
    exp_beat(MSKD, -1);
    exp_beat(MSKD, -1);
    exp_beat(D1A, -1);
    exp_beat(D1B, -1);
    exp_beat(MSKD, -1);
    exp_beat(MSKD, -1);
    push_cmd(CMD_READ, 31'h8);
    push_cmd(CMD_READ, 31'h10);
    check("afull_after_2", 128'(app_af_afull), 128'd0);
    push_cmd(CMD_READ, 31'h8);
    check("afull_after_3", 128'(app_af_afull), 128'd1);
    push_cmd(CMD_READ, 31'h10);
    check("err_af_before_5", 128'(err_flags[ERR_AF]), 128'd0);
    push_cmd(CMD_READ, 31'h20);
    check("err_af_after_5", 128'(err_flags[ERR_AF]), 128'd1);
    push_data(D4A, 16'h0);
    push_data(D4B, 16'h0);
    drain();
    tick(20);
    check("afull_cleared", 128'(app_af_afull), 128'd0);

    // illegal command, then aliased write address
    push_cmd(3'b111, 31'h0);
    tick(3);
    check("err_cmd", 128'(err_flags[ERR_CMD]), 128'd1);
    do_write(31'h8 + 31'(1 << (MEM_AW + 1)), D5A, 16'h0, D5B, 16'h0);
    tick(4);
    do_read(31'h8, D5A, D5B, 1'b1);
    drain();

    // reset during the first beat of a read
    exp_beat(D5A, -1);
    push_cmd(CMD_READ, 31'h8);
    for (int i = 0; i < 20 && !rd_data_valid; i++)
      tick();
    check("rd0_seen", 128'(rd_data_valid), 128'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 128'(rd_data_valid), 128'd0);
    check("rst_mid_data", rd_data_fifo_out, 128'd0);
    tick(3);
    rst_n = 1'b1;
    tick(12);
    check("no_beat_after_rst", 128'(sb.size()), 128'd0);
    check("err_cleared", 128'(err_flags), 128'd0);
    sb.delete();
    do_read(31'h8, D5A, D5B, 1'b1);
    drain();

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
